// File: rtl/f32_pkg.sv
// Shared single-precision FP definitions for the divider (and later the multiplier).
// Holds format constants, operand classes and the divider FSM states.
package f32_pkg;

    localparam logic [31:0] F32_QNAN = 32'h7FC00000;
    localparam int          F32_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;
    localparam int          QBITS    = 25;

    typedef enum logic [1:0] {
        ZERO,
        NORMAL,
        INF,
        NAN
    } f32_class_t;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORMALIZE,
        DONE
    } div_state_t;

    // Denormals (exp == 0) are flushed, so they classify as ZERO.
    function automatic f32_class_t classify(input logic [7:0] exp_f, input logic [22:0] frac_f);
        if (exp_f == 8'd0)
            return ZERO;
        else if (exp_f == EXP_MAX)
            return (frac_f != 23'd0) ? NAN : INF;
        else
            return NORMAL;
    endfunction

endpackage

// File: rtl/f32_div_if.sv
// Start/done handshake, operands, quotient and flags of the f32 divider.
interface f32_div_if;

    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] q;
    logic        overflow_o;
    logic        underflow_o;
    logic        div_by_zero_o;
    logic        invalid_o;

    modport master (
        output a, b, start,
        input  busy, done, q, overflow_o, underflow_o, div_by_zero_o, invalid_o
    );

    modport slave (
        input  a, b, start,
        output busy, done, q, overflow_o, underflow_o, div_by_zero_o, invalid_o
    );

endinterface

// File: rtl/f32_mant_div.sv
// Radix-2 restoring mantissa divider: one quotient bit per step, QBITS bits total.
module f32_mant_div
    import f32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [23:0] dividend,
    input  logic [23:0] divisor,
    output logic [24:0] quo,
    output logic        last,
    output logic        valid
);

    logic [25:0] rem;
    logic [23:0] dsr;
    logic [4:0]  cnt;
    logic        ge;
    logic [25:0] next_rem;

    assign ge       = rem >= {2'b00, dsr};
    assign next_rem = ge ? (rem - {2'b00, dsr}) : rem;
    assign last     = cnt == 5'(QBITS - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem   <= '0;
            dsr   <= '0;
            quo   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (load) begin
            rem   <= {2'b00, dividend};
            dsr   <= divisor;
            quo   <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (step) begin
            rem   <= next_rem << 1;
            quo   <= {quo[23:0], ge};
            cnt   <= cnt + 5'd1;
            valid <= last;
        end
    end

endmodule

// File: rtl/f32_div.sv
// Multi-cycle IEEE-754 single-precision divider q = a / b, truncating, denormals flushed.
module f32_div
    import f32_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    f32_div_if.slave   bus
);

    localparam logic signed [9:0] BIAS_S = 10'(F32_BIAS);

    div_state_t        state;
    logic [31:0]       op_a;
    logic [31:0]       op_b;
    logic              sign_q;
    logic signed [9:0] exp_d;

    f32_class_t        cls_a;
    f32_class_t        cls_b;
    logic              sgn_ab;
    logic              spec_hit;
    logic [31:0]       spec_q;
    logic              spec_inv;
    logic              spec_dbz;

    logic [24:0]       quo;
    logic              mant_last;
    logic              mant_valid;

    logic [22:0]       frac;
    logic signed [9:0] exp_n;
    logic signed [9:0] shamt;
    logic [22:0]       sub_sig;
    logic [31:0]       norm_q;
    logic              norm_ovf;
    logic              norm_unf;

    assign cls_a  = classify(op_a[30:23], op_a[22:0]);
    assign cls_b  = classify(op_b[30:23], op_b[22:0]);
    assign sgn_ab = op_a[31] ^ op_b[31];

    // Special-operand results, checked in priority order; NaN wins over everything.
    always_comb begin
        spec_hit = 1'b1;
        spec_q   = F32_QNAN;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (cls_a == NAN || cls_b == NAN) begin
            spec_q = F32_QNAN;
        end else if ((cls_a == ZERO && cls_b == ZERO) || (cls_a == INF && cls_b == INF)) begin
            spec_inv = 1'b1;
        end else if (cls_a == INF) begin
            spec_q = {sgn_ab, EXP_MAX, 23'd0};
        end else if (cls_b == INF) begin
            spec_q = {sgn_ab, 31'd0};
        end else if (cls_b == ZERO) begin
            spec_q   = {sgn_ab, EXP_MAX, 23'd0};
            spec_dbz = 1'b1;
        end else if (cls_a == ZERO) begin
            spec_q = {sgn_ab, 31'd0};
        end else begin
            spec_hit = 1'b0;
        end
    end

    f32_mant_div u_mant_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state == UNPACK && !spec_hit),
        .step     (state == DIVIDE),
        .dividend ({1'b1, op_a[22:0]}),
        .divisor  ({1'b1, op_b[22:0]}),
        .quo      (quo),
        .last     (mant_last),
        .valid    (mant_valid)
    );

    // Quotient lies in [2^23, 2^25); the top bit picks the normalisation shift.
    always_comb begin
        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        sub_sig  = '0;
        if (quo[24]) begin
            frac  = quo[23:1];
            exp_n = exp_d;
        end else begin
            frac  = quo[22:0];
            exp_n = exp_d - 10'sd1;
        end
        shamt  = 10'sd1 - exp_n;
        norm_q = {sign_q, exp_n[7:0], frac};
        if (exp_n >= 10'sd255) begin
            norm_q   = {sign_q, EXP_MAX, 23'd0};
            norm_ovf = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            norm_unf = 1'b1;
            if (shamt > 10'sd23) begin
                norm_q = {sign_q, 31'd0};
            end else begin
                sub_sig = 23'({1'b1, frac} >> shamt);
                norm_q  = {sign_q, 8'd0, sub_sig};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            op_a              <= '0;
            op_b              <= '0;
            sign_q            <= 1'b0;
            exp_d             <= '0;
            bus.busy          <= 1'b0;
            bus.done          <= 1'b0;
            bus.q             <= '0;
            bus.overflow_o    <= 1'b0;
            bus.underflow_o   <= 1'b0;
            bus.div_by_zero_o <= 1'b0;
            bus.invalid_o     <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_a     <= bus.a;
                        op_b     <= bus.b;
                        bus.busy <= 1'b1;
                        state    <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= sgn_ab;
                    exp_d  <= $signed({2'b00, op_a[30:23]}) - $signed({2'b00, op_b[30:23]}) + BIAS_S;
                    if (spec_hit) begin
                        bus.q             <= spec_q;
                        bus.overflow_o    <= 1'b0;
                        bus.underflow_o   <= 1'b0;
                        bus.div_by_zero_o <= spec_dbz;
                        bus.invalid_o     <= spec_inv;
                        bus.done          <= 1'b1;
                        state             <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (mant_last)
                        state <= NORMALIZE;
                end
                NORMALIZE: begin
                    if (mant_valid) begin
                        bus.q             <= norm_q;
                        bus.overflow_o    <= norm_ovf;
                        bus.underflow_o   <= norm_unf;
                        bus.div_by_zero_o <= 1'b0;
                        bus.invalid_o     <= 1'b0;
                        bus.done          <= 1'b1;
                        state             <= DONE;
                    end
                end
                DONE: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
